// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if
// Groups the handshake and bus signals around the MEM pipeline stage.
//   ex_mem_valid / mem_allowin / ex_mem_bus : EX -> MEM handshake and payload
//   data_sram_rdata                         : load data returned by the SRAM
//   mem_wb_valid / wb_allowin / mem_wb_bus  : MEM -> WB handshake and payload
//   mem_id_bus                              : {bypass, dest, final_result} to ID
//   wb_ex / ertn_flush                      : pipeline flush requests from WB
// Modports: slave is the MEM stage itself, master is the surrounding pipeline.
// ----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int EX_MEM_W = 190,
    parameter int MEM_WB_W = 184
);
    logic                ex_mem_valid;
    logic                mem_allowin;
    logic [EX_MEM_W-1:0] ex_mem_bus;
    logic [31:0]         data_sram_rdata;
    logic                mem_wb_valid;
    logic                wb_allowin;
    logic [MEM_WB_W-1:0] mem_wb_bus;
    logic [37:0]         mem_id_bus;
    logic                wb_ex;
    logic                ertn_flush;

    modport slave (
        input  ex_mem_valid,
        input  ex_mem_bus,
        input  data_sram_rdata,
        input  wb_allowin,
        input  wb_ex,
        input  ertn_flush,
        output mem_allowin,
        output mem_wb_valid,
        output mem_wb_bus,
        output mem_id_bus
    );

    modport master (
        output ex_mem_valid,
        output ex_mem_bus,
        output data_sram_rdata,
        output wb_allowin,
        output wb_ex,
        output ertn_flush,
        input  mem_allowin,
        input  mem_wb_valid,
        input  mem_wb_bus,
        input  mem_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Single-cycle MEM stage of an in-order pipeline. Holds one instruction from
// EX, aligns and extends load data returned by the data SRAM, and forwards the
// completed instruction to WB. Load data is buffered on the first cycle the
// instruction sits in MEM so a WB stall cannot corrupt it when EX issues new
// SRAM requests behind it.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   io    : mem_stage_if.slave (EX/WB handshakes, buses, flushes, SRAM rdata)
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int EX_MEM_W = 190,
    parameter int MEM_WB_W = 184
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  io
);

    // Sign/zero extension of the addressed byte or halfword of a load word.
    function automatic logic [31:0] load_extend(
        input logic [2:0]  ld_type,
        input logic [1:0]  low2,
        input logic [31:0] word
    );
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext_s;
        logic [31:0]        ext;
        b_s = signed'(word[{low2, 3'b000} +: 8]);
        h_s = low2[1] ? signed'(word[31:16]) : signed'(word[15:0]);
        case (ld_type)
            3'b001: begin
                ext_s = b_s;
                ext   = ext_s;
            end
            3'b010: begin
                ext_s = h_s;
                ext   = ext_s;
            end
            3'b011:  ext = {24'd0, b_s};
            3'b100:  ext = {16'd0, h_s};
            default: ext = word;
        endcase
        return ext;
    endfunction

    logic                vld_p1;
    logic [EX_MEM_W-1:0] bus_p1;
    logic [31:0]         rdata_buf_p1;
    logic                rdata_held_p1;

    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  mem_type;
    logic [1:0]  addr_low2;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;

    logic        flush;
    logic        ready_go;
    logic        allowin;
    logic        out_valid;
    logic        depart;
    logic [31:0] load_word;
    logic [31:0] final_result;

    assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, result,
            csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall} = bus_p1;

    assign flush     = io.wb_ex | io.ertn_flush;
    assign ready_go  = 1'b1;
    assign out_valid = vld_p1 & ready_go;
    assign allowin   = ~vld_p1 | (ready_go & io.wb_allowin);
    assign depart    = out_valid & io.wb_allowin;

    // ---- EX -> MEM boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (allowin) begin
            vld_p1 <= io.ex_mem_valid;
        end
    end

    // Payload carries no reset; it is meaningless whenever vld_p1 is low.
    always_ff @(posedge clk) begin
        if (io.ex_mem_valid && allowin) begin
            bus_p1 <= io.ex_mem_bus;
        end
    end

    // Capture SRAM data on the instruction's first MEM cycle. Departure or
    // flush takes priority so a back-to-back successor starts unheld.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_held_p1 <= 1'b0;
            rdata_buf_p1  <= 32'd0;
        end else if (depart || flush) begin
            rdata_held_p1 <= 1'b0;
        end else if (vld_p1 && !rdata_held_p1) begin
            rdata_held_p1 <= 1'b1;
            rdata_buf_p1  <= io.data_sram_rdata;
        end
    end

    assign load_word    = rdata_held_p1 ? rdata_buf_p1 : io.data_sram_rdata;
    assign final_result = res_from_mem ? load_extend(mem_type, addr_low2, load_word)
                                       : result;

    // ---- MEM -> WB boundary ----
    assign io.mem_allowin  = allowin;
    assign io.mem_wb_valid = out_valid;
    assign io.mem_wb_bus   = {gr_we, dest, pc, inst, final_result, csr_we, csr_re,
                              csr_num, csr_wmask, csr_wvalue, ertn, syscall};
    assign io.mem_id_bus   = {vld_p1 & gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Directed stimulus for mem_stage. Expected MEM->WB words are queued when an
// instruction is issued; an independent monitor pops and compares on every WB
// handshake. Direct checks cover reset, stall, flush and forwarding behaviour.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int EX_MEM_W = 190;
    localparam int MEM_WB_W = 184;

    logic clk;
    logic reset;

    mem_stage_if #(.EX_MEM_W(EX_MEM_W), .MEM_WB_W(MEM_WB_W)) bus_if ();

    mem_stage #(.EX_MEM_W(EX_MEM_W), .MEM_WB_W(MEM_WB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [MEM_WB_W-1:0] exp_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h0A5C_3000;
    endfunction

    function automatic logic [EX_MEM_W-1:0] mk_bus(
        input logic gr_we, input logic rfm, input logic [2:0] mt,
        input logic [1:0] low2, input logic [4:0] dest,
        input logic [31:0] pc, input logic [31:0] result);
        logic [31:0] inst;
        inst = inst_of(pc);
        return {gr_we, rfm, mt, low2, dest, pc, inst, result,
                1'b1, 1'b0, 14'h2A5, ~inst, pc ^ inst, 1'b0, 1'b1};
    endfunction

    function automatic logic [MEM_WB_W-1:0] exp_wb(
        input logic gr_we, input logic [4:0] dest,
        input logic [31:0] pc, input logic [31:0] final_result);
        logic [31:0] inst;
        inst = inst_of(pc);
        return {gr_we, dest, pc, inst, final_result,
                1'b1, 1'b0, 14'h2A5, ~inst, pc ^ inst, 1'b0, 1'b1};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(
        input logic gr_we, input logic rfm, input logic [2:0] mt,
        input logic [1:0] low2, input logic [4:0] dest,
        input logic [31:0] pc, input logic [31:0] result,
        input logic [31:0] exp_final, input bit expect_out);
        bus_if.ex_mem_valid = 1'b1;
        bus_if.ex_mem_bus   = mk_bus(gr_we, rfm, mt, low2, dest, pc, result);
        if (expect_out) exp_q.push_back(exp_wb(gr_we, dest, pc, exp_final));
    endtask

    // Monitor: one comparison per WB handshake.
    initial begin
        logic [MEM_WB_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (bus_if.mem_wb_valid === 1'b1 && bus_if.wb_allowin === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected: got %h expected no transfer", bus_if.mem_wb_bus);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus_if.mem_wb_bus !== exp) begin
                        n_err++;
                        $display("FAIL wb_bus: got %h expected %h", bus_if.mem_wb_bus, exp);
                    end
                end
            end
        end
    end

    initial begin
        reset                  = 1'b1;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.ex_mem_bus      = '0;
        bus_if.data_sram_rdata = 32'd0;
        bus_if.wb_allowin      = 1'b1;
        bus_if.wb_ex           = 1'b0;
        bus_if.ertn_flush      = 1'b0;

        // Reset state
        #12;
        check("rst_wb_valid", 64'(bus_if.mem_wb_valid), 64'd0);
        check("rst_allowin",  64'(bus_if.mem_allowin),  64'd1);
        check("rst_bypass",   64'(bus_if.mem_id_bus[37]), 64'd0);
        tick;
        reset = 1'b0;
        tick;

        // ld.b, low byte 3 of 0x80FF1234 -> 0xFFFFFF80
        issue(1'b1, 1'b1, 3'b001, 2'b11, 5'd3, 32'h1C00_0000, 32'h0000_0000, 32'hFFFF_FF80, 1'b1);
        tick;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = 32'h80FF_1234;
        tick;
        check("ldb_one_cycle", 64'(bus_if.mem_wb_valid), 64'd0);

        // ld.hu, upper half of 0x80010000 -> 0x00008001
        issue(1'b1, 1'b1, 3'b100, 2'b10, 5'd4, 32'h1C00_0004, 32'h0000_0000, 32'h0000_8001, 1'b1);
        tick;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = 32'h8001_0000;
        tick;
        check("ldhu_one_cycle", 64'(bus_if.mem_wb_valid), 64'd0);

        // ld.w stalled three cycles; SRAM data changes under the stall
        issue(1'b1, 1'b1, 3'b000, 2'b00, 5'd6, 32'h1C00_0008, 32'h0000_0000, 32'h1122_3344, 1'b1);
        tick;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = 32'h1122_3344;
        bus_if.wb_allowin      = 1'b0;
        #1;
        check("stall_allowin_c1", 64'(bus_if.mem_allowin), 64'd0);
        tick;
        bus_if.data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check("stall_allowin_c2", 64'(bus_if.mem_allowin), 64'd0);
        check("stall_held_data", 64'(bus_if.mem_id_bus[31:0]), 64'h1122_3344);
        tick;
        tick;
        bus_if.wb_allowin = 1'b1;
        tick;

        // wb_ex while MEM holds an instruction and EX offers another
        bus_if.wb_allowin = 1'b0;
        issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd7, 32'h1C00_000C, 32'h0000_0077, 32'h0000_0077, 1'b0);
        tick;
        issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd8, 32'h1C00_0010, 32'h0000_0088, 32'h0000_0088, 1'b0);
        bus_if.wb_ex = 1'b1;
        #1;
        check("preflush_bypass", 64'(bus_if.mem_id_bus[37]), 64'd1);
        tick;
        bus_if.wb_ex        = 1'b0;
        bus_if.ex_mem_valid = 1'b0;
        #1;
        check("flush_wb_valid", 64'(bus_if.mem_wb_valid), 64'd0);
        check("flush_bypass",   64'(bus_if.mem_id_bus[37]), 64'd0);
        check("flush_allowin",  64'(bus_if.mem_allowin), 64'd1);

        // ertn_flush together with an arriving instruction: flush wins
        issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd9, 32'h1C00_0014, 32'h0000_0099, 32'h0000_0099, 1'b0);
        bus_if.ertn_flush = 1'b1;
        tick;
        bus_if.ertn_flush   = 1'b0;
        bus_if.ex_mem_valid = 1'b0;
        #1;
        check("ertn_arrival_dropped", 64'(bus_if.mem_wb_valid), 64'd0);
        bus_if.wb_allowin = 1'b1;
        tick;

        // Back-to-back: ALU op, ld.h, ld.bu
        issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd5, 32'h1C00_0020, 32'h1234_5678, 32'h1234_5678, 1'b1);
        tick;
        issue(1'b1, 1'b1, 3'b010, 2'b00, 5'd10, 32'h1C00_0024, 32'h0000_0000, 32'hFFFF_8765, 1'b1);
        #1;
        check("alu_id_bus", 64'(bus_if.mem_id_bus), 64'({1'b1, 5'd5, 32'h1234_5678}));
        check("b2b_allowin", 64'(bus_if.mem_allowin), 64'd1);
        tick;
        issue(1'b1, 1'b1, 3'b011, 2'b01, 5'd11, 32'h1C00_0028, 32'h0000_0000, 32'h0000_00A5, 1'b1);
        bus_if.data_sram_rdata = 32'h0000_8765;
        tick;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = 32'h0000_A500;
        tick;
        tick;

        // Reset asserted mid-cycle while a load is stalled
        bus_if.wb_allowin = 1'b0;
        issue(1'b1, 1'b1, 3'b000, 2'b00, 5'd12, 32'h1C00_0030, 32'h0000_0000, 32'h0000_0055, 1'b0);
        tick;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = 32'h0000_0055;
        tick;
        #3;
        reset = 1'b1;
        #2;
        check("midrst_wb_valid", 64'(bus_if.mem_wb_valid), 64'd0);
        check("midrst_allowin",  64'(bus_if.mem_allowin),  64'd1);
        check("midrst_bypass",   64'(bus_if.mem_id_bus[37]), 64'd0);
        tick;
        reset             = 1'b0;
        bus_if.wb_allowin = 1'b1;
        #1;
        check("postrst_wb_valid", 64'(bus_if.mem_wb_valid), 64'd0);
        tick;
        issue(1'b1, 1'b1, 3'b000, 2'b00, 5'd13, 32'h1C00_0034, 32'h0000_0000, 32'hCAFE_F00D, 1'b1);
        tick;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = 32'hCAFE_F00D;
        tick;
        tick;
        tick;

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
